// File: rtl/next_pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_fetch_ctrl_pkg
// Brief    : Shared FSM state encoding and default widths for the fetch controller.
// Revision : 1.0  initial release
// ============================================================================
package next_pc_fetch_ctrl_pkg;

    localparam int c_ADDR_W_DEFAULT  = 8;
    localparam int c_INSTR_W_DEFAULT = 32;
    localparam int c_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/next_pc_fetch_ctrl_fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : fetch_timeout_ctr
// Brief    : Saturating cycle counter with clear/enable; flags the last allowed cycle.
// Revision : 1.0  initial release
// ============================================================================
module fetch_timeout_ctr
    import next_pc_fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int               c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != c_LAST)) begin
            cnt_q <= cnt_q + c_CNT_W'(1);
        end
    end

    // High during the TIMEOUT-th enabled cycle, i.e. the cycle that must not pass unacked.
    assign expired_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/next_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_fetch_ctrl
// Brief    : Drives PC-register PCin, fetches over req/ack and hands words to decode
//            over valid/ready. Optional fetch watchdog enabled by FETCH_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module next_pc_fetch_ctrl
    import next_pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W_DEFAULT,
    parameter int INSTR_W = c_INSTR_W_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic               clock_reg,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt_req,
`ifdef FETCH_TIMEOUT_EN
    output logic               fetch_err,
`endif
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               squash_q, squash_d;
    logic               w_timeout;

`ifdef FETCH_TIMEOUT_EN
    logic w_expired;
    logic fetch_err_q;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i     (clock_reg),
        .rst_ni    (reset),
        .clr_i     (state_q == S_ISSUE),
        .en_i      ((state_q == S_REQ) && !imem_ack),
        .expired_o (w_expired)
    );

    // A redirect in the expiry cycle wins, so the error is only raised without one.
    assign w_timeout = (state_q == S_REQ) && !imem_ack && !br_valid && w_expired;

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            fetch_err_q <= 1'b0;
        end else if (w_timeout) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        instr_d      = instr_q;
        squash_d     = squash_q;
        pc_next      = pc;
        case (state_q)
            S_ISSUE: begin
                if (br_valid) begin
                    pc_next = br_target;
                end else begin
                    fetch_addr_d = pc;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (squash_q || br_valid) begin
                        squash_d = 1'b0;
                        state_d  = S_ISSUE;
                        if (br_valid) begin
                            pc_next = br_target;
                        end
                    end else begin
                        instr_d = imem_data;
                        pc_next = fetch_addr_q + ADDR_W'(1);
                        state_d = S_VALID;
                    end
                end else if (br_valid) begin
                    // The outstanding request keeps its old address; its data is dropped on ack.
                    pc_next  = br_target;
                    squash_d = 1'b1;
                end else if (w_timeout) begin
                    squash_d = 1'b0;
                    state_d  = S_HALT;
                end
            end
            S_VALID: begin
                if (br_valid) begin
                    pc_next = br_target;
                    state_d = S_ISSUE;
                end else if (instr_ready) begin
                    state_d = halt_req ? S_HALT : S_ISSUE;
                end
            end
            S_HALT: begin
                if (br_valid) begin
                    pc_next = br_target;
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state_q      <= S_ISSUE;
            fetch_addr_q <= '0;
            instr_q      <= '0;
            squash_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
            squash_q     <= squash_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = fetch_addr_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_VALID);
    assign halted      = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_next_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_next_pc_fetch_ctrl
// Brief    : Directed bench with a transaction-level fetch model and closed PC loop.
// Revision : 1.0  initial release
// ============================================================================
module tb_next_pc_fetch_ctrl;

    logic        clock_reg = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic [7:0]  pc_next;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic [7:0]  br_target;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    bit ack_en   = 1'b1;
    bit bad_data = 1'b0;
    int ack_lat  = 0;
    bit m_en     = 1'b1;

    logic [7:0]  req_q[$];
    logic [31:0] vin_q[$];
    int          vcyc_q[$];

    next_pc_fetch_ctrl dut (
        .clock_reg   (clock_reg),
        .reset       (reset),
        .pc          (pc),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .halt_req    (halt_req),
`ifdef FETCH_TIMEOUT_EN
        .fetch_err   (fetch_err),
`endif
        .halted      (halted)
    );

    always #5 clock_reg = ~clock_reg;

    always @(posedge clock_reg) cyc <= cyc + 1;

    // PC register closing the loop: loads PCin every clock.
    always @(posedge clock_reg or negedge reset) begin
        if (!reset) pc <= 8'h00;
        else        pc <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: got no event expected one within bound (t=%0t)", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_reg);
        #1;
    endtask

    task automatic clear_logs();
        req_q.delete();
        vin_q.delete();
        vcyc_q.delete();
    endtask

    task automatic wait_req(input string name, input logic [7:0] exp);
        int n = 0;
        while (req_q.size() == 0 && n < 60) begin
            tick(1);
            n++;
        end
        if (req_q.size() == 0) fail_bound(name);
        else                   chk(name, req_q.pop_front(), exp);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp);
        int n = 0;
        while (vin_q.size() == 0 && n < 60) begin
            tick(1);
            n++;
        end
        if (vin_q.size() == 0) fail_bound(name);
        else                   chk(name, vin_q.pop_front(), exp);
    endtask

    // Memory: acks after ack_lat waiting cycles of a held request.
    initial begin
        int wcnt = 0;
        imem_ack  = 1'b0;
        imem_data = '0;
        forever begin
            @(posedge clock_reg);
            #3;
            imem_ack = 1'b0;
            if (reset && imem_req && ack_en) begin
                if (wcnt >= ack_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = bad_data ? 32'hDEADBEEF : mem_word(imem_addr);
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Transaction model: what must be visible this cycle and where PCin must point.
    bit          m_req, m_valid, m_halt, m_squash, m_first, p_req, p_valid;
    logic [7:0]  m_addr, m_req_addr, m_pcn;
    logic [31:0] m_instr;

    always @(negedge clock_reg) begin
        if (!reset) begin
            m_req = 0; m_valid = 0; m_halt = 0; m_squash = 0; m_first = 0;
            m_addr = 8'h00; p_req = 0; p_valid = 0;
        end else begin
            if (m_en) begin
                chk("m_imem_req", imem_req, m_req);
                chk("m_instr_valid", instr_valid, m_valid);
                chk("m_halted", halted, m_halt);
                m_pcn = pc;
                if (m_req) begin
                    if (m_first) begin
                        chk("m_fetch_addr", imem_addr, m_addr);
                        m_req_addr = m_addr;
                        m_first    = 0;
                        m_squash   = 0;
                    end else begin
                        chk("m_addr_hold", imem_addr, m_req_addr);
                    end
                    if (br_valid) begin
                        m_squash = 1; m_pcn = br_target; m_addr = br_target;
                    end
                    if (imem_ack) begin
                        m_req = 0;
                        if (!m_squash) begin
                            m_valid = 1;
                            m_instr = mem_word(m_req_addr);
                            m_addr  = m_req_addr + 8'd1;
                            m_pcn   = m_addr;
                        end
                        m_squash = 0;
                    end
                end else if (m_valid) begin
                    chk("m_instr", instr, m_instr);
                    if (br_valid) begin
                        m_valid = 0; m_pcn = br_target; m_addr = br_target;
                    end else if (instr_ready) begin
                        m_valid = 0; m_halt = halt_req;
                    end
                end else if (m_halt) begin
                    if (br_valid) begin
                        m_halt = 0; m_pcn = br_target; m_addr = br_target;
                    end
                end else begin
                    if (br_valid) begin
                        m_pcn = br_target; m_addr = br_target;
                    end else begin
                        m_req = 1; m_first = 1;
                    end
                end
                chk("m_pc_next", pc_next, m_pcn);
            end
            if (imem_req && !p_req) req_q.push_back(imem_addr);
            if (instr_valid && !p_valid) begin
                vin_q.push_back(instr);
                vcyc_q.push_back(cyc);
            end
            p_req   = imem_req;
            p_valid = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        instr_ready = 1'b1;
        br_valid    = 1'b0;
        br_target   = 8'h00;
        halt_req    = 1'b0;
        tick(2);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_next", pc_next, 8'h00);
`ifdef FETCH_TIMEOUT_EN
        chk("rst_fetch_err", fetch_err, 1'b0);
`endif
        reset = 1'b1;

        // Sequential stream, same-cycle ack, decode always ready.
        tick(9);
        chk("seq_nreq", req_q.size(), 3);
        chk("seq_nvalid", vin_q.size(), 3);
        if (req_q.size() >= 3) begin
            chk("seq_addr0", req_q[0], 8'h00);
            chk("seq_addr1", req_q[1], 8'h01);
            chk("seq_addr2", req_q[2], 8'h02);
        end
        if (vin_q.size() >= 3) begin
            chk("seq_instr0", vin_q[0], 32'hA500FF3C);
            chk("seq_instr1", vin_q[1], 32'hA501FE3D);
            chk("seq_instr2", vin_q[2], 32'hA502FD3E);
            chk("seq_gap01", vcyc_q[1] - vcyc_q[0], 3);
            chk("seq_gap12", vcyc_q[2] - vcyc_q[1], 3);
        end
        clear_logs();

        // Redirect to 0xFF from ISSUE, then the fetch there wraps PC to 0x00.
        br_valid = 1'b1; br_target = 8'hFF;
        tick(1);
        br_valid = 1'b0;
        wait_req("wrap_req", 8'hFF);
        wait_valid("wrap_instr", 32'hA5FF00C3);
        chk("wrap_pc", pc, 8'h00);
        wait_req("wrap_next_req", 8'h00);

        // Redirect during a slow request; the late DEADBEEF must be dropped.
        clear_logs();
        ack_lat = 2; bad_data = 1'b1;
        wait_req("sq_req", 8'h01);
        br_valid = 1'b1; br_target = 8'h40;
        tick(1);
        br_valid = 1'b0;
        vin_q.delete();
        wait_req("sq_next_req", 8'h40);
        chk("sq_no_valid", vin_q.size(), 0);
        bad_data = 1'b0; ack_lat = 0; instr_ready = 1'b0;

        // Decode back-pressure for 5 cycles.
        wait_valid("stall_instr", 32'hA540BF7C);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr_hold", instr, 32'hA540BF7C);
            chk("stall_pc", pc, 8'h41);
            chk("stall_no_req", imem_req, 1'b0);
            tick(1);
        end
        instr_ready = 1'b1;
        wait_req("stall_next_req", 8'h41);

        // Halt at the handshake, then resume by redirect.
        halt_req = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_halted", halted, 1'b1);
            chk("halt_no_req", imem_req, 1'b0);
            chk("halt_pc", pc, 8'h42);
            tick(1);
        end
        halt_req = 1'b0;
        clear_logs();
        br_valid = 1'b1; br_target = 8'h10;
        tick(1);
        br_valid = 1'b0;
        wait_req("resume_req", 8'h10);
        chk("resume_halted", halted, 1'b0);
        wait_valid("resume_instr", 32'hA510EF2C);

        // Reset in the middle of a pending request.
        clear_logs();
        ack_lat = 3;
        wait_req("mrst_req", 8'h11);
        reset = 1'b0;
        tick(1);
        chk("mrst_imem_req", imem_req, 1'b0);
        chk("mrst_instr_valid", instr_valid, 1'b0);
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_pc_next", pc_next, 8'h00);
        reset = 1'b1;
        clear_logs();
        ack_lat = 0;
        wait_req("mrst_next_req", 8'h00);
        wait_valid("mrst_instr0", 32'hA500FF3C);

        // Redirect while a word waits in VALID drops it.
        instr_ready = 1'b0;
        wait_valid("drop_instr", 32'hA501FE3D);
        br_valid = 1'b1; br_target = 8'h80;
        tick(1);
        br_valid = 1'b0;
        instr_ready = 1'b1;
        clear_logs();
        wait_req("drop_next_req", 8'h80);
        wait_valid("drop_next_instr", 32'hA5807FBC);

`ifdef FETCH_TIMEOUT_EN
        begin
            int n = 0;
            m_en = 1'b0; ack_en = 1'b0;
            clear_logs();
            wait_req("to_req", 8'h81);
            chk("to_err_before", fetch_err, 1'b0);
            while (!halted && n < 40) begin
                tick(1);
                n++;
            end
            chk("to_cycles", n, 14);
            chk("to_err", fetch_err, 1'b1);
            chk("to_halted", halted, 1'b1);
            chk("to_no_req", imem_req, 1'b0);
            reset = 1'b0;
            tick(1);
            chk("to_err_cleared", fetch_err, 1'b0);
            reset = 1'b1; ack_en = 1'b1; m_en = 1'b1;
        end
`endif

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
